// File: rtl/core_regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: read ports, forward ports,
// write port, scoreboard controls and the scoreboard state output.
// With NFP = 0 the forward signals keep a width of one and the core ignores them.
interface core_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NFP  = 2
);
    localparam int AW  = $clog2(NREG);
    localparam int NFW = (NFP > 0) ? NFP : 1;

    logic                rd_latch;
    logic [NRP-1:0]      i_re;
    logic [NRP*AW-1:0]   i_raddr;
    logic [NRP*XLEN-1:0] o_rdata;
    logic [NRP-1:0]      o_hazard;
    logic [NFW-1:0]      i_fwd;
    logic [NFW*AW-1:0]   i_faddr;
    logic [NFW*XLEN-1:0] i_fdata;
    logic                i_we;
    logic [AW-1:0]       i_waddr;
    logic [XLEN-1:0]     i_wdata;
    logic                i_set;
    logic [AW-1:0]       i_set_addr;
    logic                i_flush;
    logic [NREG-1:0]     o_busy;

    modport master (
        output rd_latch, i_re, i_raddr, i_fwd, i_faddr, i_fdata,
               i_we, i_waddr, i_wdata, i_set, i_set_addr, i_flush,
        input  o_rdata, o_hazard, o_busy
    );

    modport slave (
        input  rd_latch, i_re, i_raddr, i_fwd, i_faddr, i_fdata,
               i_we, i_waddr, i_wdata, i_set, i_set_addr, i_flush,
        output o_rdata, o_hazard, o_busy
    );
endinterface

// File: rtl/core_regfile_sb.sv
// Register file with a busy-bit scoreboard and forwarding. Each read port
// resolves its source at the clock edge: either a value captured in a per-port
// latch (zero, forwarded data, write bypass, held data) or a live lookup of
// storage at the registered address. Storage is deliberately not reset.
module core_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NFP  = 2
) (
    input logic              clk,
    input logic              rst_n,
    core_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:0] busy_full;

    logic [NRP-1:0]  src_lat_q, src_lat_d;
    logic [NRP-1:0]  hz_q, hz_d;
    logic [NRP-1:0]  fhit;
    logic [XLEN-1:0] lat_q [NRP];
    logic [XLEN-1:0] lat_d [NRP];
    logic [AW-1:0]   addr_q [NRP];
    logic [AW-1:0]   addr_d [NRP];
    logic [AW-1:0]   ra [NRP];
    logic [XLEN-1:0] rdata_cur [NRP];

    assign busy_full  = {busy_q, 1'b0};
    assign bus.o_busy = busy_full;

    // Storage write port; register 0 is hard zero and never written.
    always_ff @(posedge clk) begin
        if (bus.i_we && bus.i_waddr != '0)
            mem[bus.i_waddr] <= bus.i_wdata;
    end

    // Scoreboard: flush wins, then a new producer wins over a clearing write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (bus.i_flush) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (bus.i_set && bus.i_set_addr == AW'(r))
                    busy_q[r] <= 1'b1;
                else if (bus.i_we && bus.i_waddr == AW'(r))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    // Read outputs: latched value or live storage at the captured address.
    always_comb begin
        bus.o_rdata  = '0;
        bus.o_hazard = hz_q;
        for (int p = 0; p < NRP; p++) begin
            rdata_cur[p] = src_lat_q[p] ? lat_q[p] : mem[addr_q[p]];
            bus.o_rdata[p*XLEN +: XLEN] = rdata_cur[p];
        end
    end

    // Per-port source selection in priority order; stall snapshots the
    // current output so a later write to a storage-sourced address cannot leak in.
    always_comb begin
        fhit = '0;
        for (int p = 0; p < NRP; p++) begin
            ra[p]        = bus.i_raddr[p*AW +: AW];
            src_lat_d[p] = 1'b1;
            lat_d[p]     = '0;
            hz_d[p]      = 1'b0;
            addr_d[p]    = addr_q[p];
            if (bus.rd_latch) begin
                lat_d[p] = rdata_cur[p];
                hz_d[p]  = hz_q[p];
            end else if (bus.i_re[p] && ra[p] != '0) begin
                for (int k = NFP - 1; k >= 0; k--) begin
                    if (bus.i_fwd[k] && bus.i_faddr[k*AW +: AW] == ra[p]) begin
                        fhit[p]  = 1'b1;
                        lat_d[p] = bus.i_fdata[k*XLEN +: XLEN];
                    end
                end
                if (!fhit[p]) begin
                    if (bus.i_we && bus.i_waddr == ra[p]) begin
                        lat_d[p] = bus.i_wdata;
                    end else if (busy_full[ra[p]]) begin
                        hz_d[p] = 1'b1;
                    end else begin
                        src_lat_d[p] = 1'b0;
                        addr_d[p]    = ra[p];
                    end
                end
            end
        end
    end

    // Per-port read state; reset selects the latch holding zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_lat_q <= '1;
            hz_q      <= '0;
            for (int p = 0; p < NRP; p++) begin
                lat_q[p]  <= '0;
                addr_q[p] <= '0;
            end
        end else begin
            src_lat_q <= src_lat_d;
            hz_q      <= hz_d;
            for (int p = 0; p < NRP; p++) begin
                lat_q[p]  <= lat_d[p];
                addr_q[p] <= addr_d[p];
            end
        end
    end
endmodule

// File: tb/tb_core_regfile_sb.sv
// Directed bench for core_regfile_sb with default parameters
// (XLEN 32, NREG 32, NRP 2, NFP 2).
module tb_core_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    core_regfile_sb_if #(.XLEN(32), .NREG(32), .NRP(2), .NFP(2)) bus ();

    core_regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .NFP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.rd_latch   = 1'b0;
        bus.i_re       = '0;
        bus.i_raddr    = '0;
        bus.i_fwd      = '0;
        bus.i_faddr    = '0;
        bus.i_fdata    = '0;
        bus.i_we       = 1'b0;
        bus.i_waddr    = '0;
        bus.i_wdata    = '0;
        bus.i_set      = 1'b0;
        bus.i_set_addr = '0;
        bus.i_flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.i_we = 1'b1; bus.i_waddr = 5'(a); bus.i_wdata = d;
    endtask

    task automatic rd(input int p, input int a);
        bus.i_re[p] = 1'b1;
        bus.i_raddr[p*5 +: 5] = 5'(a);
    endtask

    function automatic logic [31:0] rdata(input int p);
        return bus.o_rdata[p*32 +: 32];
    endfunction

    initial begin
        idle();
        #12;
        check("reset_rdata", bus.o_rdata, 64'h0);
        check("reset_hazard", bus.o_hazard, 64'h0);
        check("reset_busy", bus.o_busy, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // write x5, then read it back from storage
        idle(); wr(5, 32'h1234); step();
        idle(); rd(0, 5); step();
        check("x5_rdata", rdata(0), 64'h1234);
        check("x5_hazard", bus.o_hazard[0], 64'h0);

        // forward beats write bypass; lowest forward port wins
        idle(); wr(7, 32'hAA); rd(1, 7);
        bus.i_fwd = 2'b01; bus.i_faddr = {5'd0, 5'd7}; bus.i_fdata = {32'h0, 32'hBB};
        step();
        check("fwd0_over_we", rdata(1), 64'hBB);
        idle(); rd(1, 7);
        bus.i_fwd = 2'b11; bus.i_faddr = {5'd7, 5'd7}; bus.i_fdata = {32'hCC, 32'hBB};
        step();
        check("fwd0_over_fwd1", rdata(1), 64'hBB);
        idle(); rd(1, 7); step();
        check("x7_storage", rdata(1), 64'hAA);

        // scoreboard hazard then write bypass clears it
        idle(); bus.i_set = 1'b1; bus.i_set_addr = 5'd9; step();
        check("x9_busy_set", bus.o_busy[9], 64'h1);
        idle(); rd(0, 9); step();
        check("x9_hazard", bus.o_hazard[0], 64'h1);
        check("x9_hz_rdata", rdata(0), 64'h0);
        idle(); rd(0, 9); wr(9, 32'h55); step();
        check("x9_bypass", rdata(0), 64'h55);
        check("x9_bypass_hz", bus.o_hazard[0], 64'h0);
        check("x9_busy_clr", bus.o_busy[9], 64'h0);

        // forwarding does not clear busy
        idle(); bus.i_set = 1'b1; bus.i_set_addr = 5'd10; step();
        idle(); bus.i_fwd = 2'b01; bus.i_faddr = {5'd0, 5'd10}; bus.i_fdata = {32'h0, 32'h99};
        rd(1, 10); step();
        check("x10_fwd_data", rdata(1), 64'h99);
        check("x10_still_busy", bus.o_busy[10], 64'h1);

        // hazard uses pre-edge busy: set and read x11 same cycle
        idle(); bus.i_set = 1'b1; bus.i_set_addr = 5'd11; rd(0, 11); step();
        check("x11_no_hazard", bus.o_hazard[0], 64'h0);

        // set and write same register: stays busy, storage updated; then flush
        idle(); bus.i_set = 1'b1; bus.i_set_addr = 5'd3; wr(3, 32'h33); step();
        check("x3_busy", bus.o_busy[3], 64'h1);
        idle(); bus.i_flush = 1'b1; bus.i_set = 1'b1; bus.i_set_addr = 5'd6; step();
        check("flush_busy", bus.o_busy, 64'h0);
        idle(); rd(0, 3); step();
        check("x3_storage", rdata(0), 64'h33);

        // stall holds data across a rewrite of the read register
        idle(); wr(4, 32'h77); step();
        idle(); rd(0, 4); step();
        check("x4_first", rdata(0), 64'h77);
        for (int i = 0; i < 3; i++) begin
            idle(); bus.rd_latch = 1'b1; rd(0, 4); wr(4, 32'h88); step();
            check("x4_held", rdata(0), 64'h77);
        end
        idle(); rd(0, 4); step();
        check("x4_reread", rdata(0), 64'h88);

        // stall holds a hazard
        idle(); bus.i_set = 1'b1; bus.i_set_addr = 5'd12; step();
        idle(); rd(1, 12); step();
        check("x12_hazard", bus.o_hazard[1], 64'h1);
        idle(); bus.rd_latch = 1'b1; wr(12, 32'h12); bus.i_set = 1'b1; bus.i_set_addr = 5'd12; step();
        check("x12_hz_held", bus.o_hazard[1], 64'h1);

        // register 0: write, set and read all ignored; no forward from x0 write
        idle(); wr(0, 32'hFFFF); bus.i_set = 1'b1; bus.i_set_addr = 5'd0; rd(0, 0); step();
        check("x0_rdata", rdata(0), 64'h0);
        check("x0_hazard", bus.o_hazard[0], 64'h0);
        check("x0_busy", bus.o_busy[0], 64'h0);
        idle(); rd(0, 0); bus.i_fwd = 2'b01; bus.i_faddr = '0; bus.i_fdata = {32'h0, 32'h5A5A}; step();
        check("x0_fwd_ignored", rdata(0), 64'h0);

        // asynchronous reset in the middle of a stall
        idle(); rd(0, 4); rd(1, 12); step();
        check("pre_rst_x4", rdata(0), 64'h88);
        check("pre_rst_busy12", bus.o_busy[12], 64'h1);
        idle(); bus.rd_latch = 1'b1; step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rdata", bus.o_rdata, 64'h0);
        check("rst_hazard", bus.o_hazard, 64'h0);
        check("rst_busy", bus.o_busy, 64'h0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        idle(); rd(0, 4); step();
        check("post_rst_x4", rdata(0), 64'h88);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
